hilo_multiplier: RTL
====================

HILO_MULTIPLIER -- requirements
Module: hilo_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; the HI and LO registers are each WIDTH bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, command strobe qualified by funct.
REQ-005 SHALL have port funct, input, 6, command code: MULTU 6'b011001, MFHI 6'b010000, MFLO 6'b010010; all other codes are ignored.
REQ-006 SHALL have ports a and b, input, WIDTH, the unsigned multiplicand and multiplier.
REQ-007 SHALL have port busy, output, 1, high while a multiply is in progress; the pipeline stalls on it.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse marking the HI/LO update.
REQ-009 SHALL have port hilo_out, output, WIDTH, registered HI or LO read data.
REQ-010 SHALL have port hilo_valid, output, 1, a one-cycle pulse qualifying hilo_out.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and FIN.
- IDLE to RUN on start with MULTU: latch a into the multiplicand register and b into the multiplier register, and clear the 2*WIDTH accumulator.
REQ-012 In each RUN cycle, the FSM SHALL add the shifted multiplicand to the accumulator when the multiplier LSB is 1, then shift the multiplier right by 1 and the multiplicand left by 1, using unsigned arithmetic and a WIDTH-cycle counter.
REQ-013 After WIDTH RUN cycles, the FSM SHALL go to FIN, then from FIN to IDLE after one cycle.
- In FIN: write HI = acc[2W-1:W] and LO = acc[W-1:0], and pulse done.
REQ-014 Latency SHALL be WIDTH+1 cycles: start is sampled at edge 0 and done is high during the cycle after edge WIDTH+1 (33 cycles for WIDTH=32).
REQ-015 busy SHALL be high in RUN and FIN, and low in IDLE.
REQ-016 start during RUN or FIN SHALL be ignored with no state change, including MFHI and MFLO.
REQ-017 MFHI or MFLO with start in IDLE SHALL drive hilo_out = HI or LO at the next edge and pulse hilo_valid for one cycle.
REQ-018 The FSM SHALL not move out of IDLE on MFHI or MFLO.
REQ-019 hilo_out SHALL hold its last value when no read is in progress.
REQ-020 HI and LO SHALL be written only in FIN; a read in the cycle after done returns the new product.
REQ-021 funct codes other than MULTU, MFHI and MFLO SHALL cause no action, even when start is high.

Reset
REQ-022 On rst_n low, the block SHALL take the following values asynchronously:
- FSM = IDLE; HI, LO, accumulator and counter = 0.
- busy = 0, done = 0, hilo_valid = 0, hilo_out = 0.
REQ-023 Reset during RUN SHALL abort the multiply with no HI/LO update, and the first start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro MULTU_EARLY_TERM_EN, when defined, SHALL add early termination: RUN exits to FIN after any cycle whose post-shift multiplier register is 0.
- Minimum 1 RUN cycle; latency = max(1, index of highest set bit of b + 1) + 1.
REQ-025 Without MULTU_EARLY_TERM_EN, RUN SHALL always take exactly WIDTH cycles.
REQ-026 Products SHALL be identical with and without MULTU_EARLY_TERM_EN.

Structure
REQ-027 The funct constants (MULTU, MFHI, MFLO) and the FSM state encoding SHALL live in shared package mips_funct_pkg, reused by the ALU decode path.
REQ-028 The shift-add datapath (accumulator, shifted operands, counter) SHALL be a sub-module named multu_datapath, and the FSM and HI/LO registers SHALL stay in hilo_multiplier.

Verification
REQ-029 The bench SHALL cover MULTU a=3, b=5 followed by MFLO.
- Response: done 33 cycles after start, then hilo_out = 15 with hilo_valid; MFHI returns 0.
REQ-030 The bench SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
- Response: HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-031 The bench SHALL cover MULTU a=0x80000000, b=2.
- Response: HI = 0x00000001, LO = 0x00000000.
REQ-032 The bench SHALL cover a second MULTU (a=7, b=7) and an MFHI issued at cycle 10 of a running multiply (a=2, b=3).
- Response: both ignored; HI/LO = 0 and 6 after the first multiply completes.
REQ-033 The bench SHALL cover rst_n pulsed low at cycle 16 of MULTU a=9, b=9.
- Response: busy drops immediately and HI/LO read back 0.
- A following MULTU 9*9 yields LO = 81.
REQ-034 The bench SHALL cover MULTU_EARLY_TERM_EN defined, MULTU a=100, b=1.
- Response: done on cycle 2 after start, LO = 100.
- With b=0: done on cycle 2, HI = 0 and LO = 0.

Source files
------------

// File: rtl/mips_funct_pkg.sv
// mips_funct_pkg: funct codes and multiplier FSM encoding shared with the ALU decode path
package mips_funct_pkg;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } mult_state_e;

    function automatic logic is_hilo_read(input logic [5:0] f);
        return f == FUNCT_MFHI || f == FUNCT_MFLO;
    endfunction
endpackage

// File: rtl/multu_datapath.sv
// multu_datapath: unsigned shift-add multiply datapath (accumulator, shifted operands, counter)
// MULTU_EARLY_TERM_EN: also flag the last step once the post-shift multiplier is zero
module multu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        acc_d    = load ? '0 : step ? acc_q + (mplier_q[0] ? mcand_q : '0) : acc_q;
        mcand_d  = load ? {{WIDTH{1'b0}}, a} : step ? mcand_q << 1 : mcand_q;
        mplier_d = load ? b : step ? mplier_q >> 1 : mplier_q;
        cnt_d    = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc = acc_q;

`ifdef MULTU_EARLY_TERM_EN
    // The multiplier after this step's shift is mplier_q[WIDTH-1:1]; once zero nothing more accumulates
    assign last = (cnt_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last = cnt_q == CW'(WIDTH - 1);
`endif
endmodule

// File: rtl/hilo_multiplier.sv
// hilo_multiplier: MIPS MULTU unit with HI/LO registers and MFHI/MFLO reads
// MULTU_EARLY_TERM_EN (in multu_datapath) enables early termination of the multiply
module hilo_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_out,
    output logic             hilo_valid
);
    import mips_funct_pkg::*;

    mult_state_e        state_q;
    logic [WIDTH-1:0]   hi_q, lo_q, hilo_out_q;
    logic               busy_q, done_q, hilo_valid_q;
    logic               load, step, last;
    logic [2*WIDTH-1:0] acc;

    assign load = state_q == ST_IDLE && start && funct == FUNCT_MULTU;
    assign step = state_q == ST_RUN;

    multu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a     (a),
        .b     (b),
        .acc   (acc),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            hilo_out_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hilo_valid_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            hilo_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else if (start && is_hilo_read(funct)) begin
                        hilo_out_q   <= funct == FUNCT_MFHI ? hi_q : lo_q;
                        hilo_valid_q <= 1'b1;
                    end
                end
                ST_RUN: if (last) state_q <= ST_FIN;
                ST_FIN: begin
                    hi_q    <= acc[2*WIDTH-1:WIDTH];
                    lo_q    <= acc[WIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign hilo_out   = hilo_out_q;
    assign hilo_valid = hilo_valid_q;
endmodule
